// File: rtl/multi_clk_generator.sv
// Multi-channel programmable clock divider: per-channel half-period counters with
// deferred divisor reload, clean stop on disable, rising-edge ticks and global phase align.
module multi_clk_generator #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 24,
    localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              in_clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              align,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [CNT_W-1:0]  active_q [NUM_CH];
    logic [CNT_W-1:0]  active_d [NUM_CH];
    logic [CNT_W-1:0]  pdiv_q   [NUM_CH];
    logic [CNT_W-1:0]  pdiv_d   [NUM_CH];
    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] wr_hit;

    // Equality decode leaves out-of-range selects with no matching channel.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            wr_hit[i] = cfg_we && (cfg_sel == SEL_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            count_d[i]  = count_q[i];
            active_d[i] = active_q[i];
            pdiv_d[i]   = pdiv_q[i];
            out_d[i]    = out_q[i];
            tick_d[i]   = 1'b0;
            pend_d[i]   = pend_q[i];

            if (align) begin
                count_d[i] = '0;
                out_d[i]   = 1'b0;
                if (pend_q[i]) begin
                    active_d[i] = pdiv_q[i];
                    pend_d[i]   = 1'b0;
                end
            end else if (!ch_en[i] && !out_q[i]) begin
                count_d[i] = '0;
            end else if (count_q[i] >= active_q[i]) begin
                // A disabled channel still reaches here while high, so it always ends its high phase.
                count_d[i] = '0;
                out_d[i]   = ~out_q[i];
                tick_d[i]  = ~out_q[i];
                if (pend_q[i]) begin
                    active_d[i] = pdiv_q[i];
                    pend_d[i]   = 1'b0;
                end
            end else begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end

            // A write landing with a reload is kept pending for the next reload point.
            if (wr_hit[i]) begin
                pdiv_d[i] = cfg_div;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                count_q[i]  <= '0;
                active_q[i] <= CNT_W'(DEFAULT_DIV);
                pdiv_q[i]   <= '0;
            end
            out_q  <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            pdiv_q   <= pdiv_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
        end
    end

    assign out_clk     = out_q;
    assign rise_tick   = tick_q;
    assign cfg_pending = pend_q;

endmodule

// File: tb/tb_multi_clk_generator.sv
// Bench for multi_clk_generator: directed scenarios plus random traffic against a
// countdown-to-next-toggle reference model of each channel.
module tb_multi_clk_generator;

    // Five channels so that out-of-range selects (5..7) are representable.
    localparam int unsigned NUM_CH  = 5;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned DEF_DIV = 24;
    localparam int unsigned SEL_W   = 3;

    logic              in_clk  = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] ch_en   = '0;
    logic              align   = 1'b0;
    logic              cfg_we  = 1'b0;
    logic [SEL_W-1:0]  cfg_sel = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [NUM_CH-1:0] out_clk;
    logic [NUM_CH-1:0] rise_tick;
    logic [NUM_CH-1:0] cfg_pending;

    int checks = 0;
    int errors = 0;

    always #5 in_clk = ~in_clk;

    multi_clk_generator #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .in_clk      (in_clk),
        .reset_n     (reset_n),
        .ch_en       (ch_en),
        .align       (align),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_div     (cfg_div),
        .out_clk     (out_clk),
        .rise_tick   (rise_tick),
        .cfg_pending (cfg_pending)
    );

    // Reference model: level, cycles left until next toggle, divisors.
    bit     m_lvl  [NUM_CH];
    bit     m_tick [NUM_CH];
    bit     m_pend [NUM_CH];
    longint m_left [NUM_CH];
    longint m_act  [NUM_CH];
    longint m_pdiv [NUM_CH];

    function automatic void model_reset();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
            m_act[c] = DEF_DIV; m_pdiv[c] = 0; m_left[c] = DEF_DIV + 1;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            m_tick[c] = 0;
            if (align) begin
                m_lvl[c] = 0;
                if (m_pend[c]) begin m_act[c] = m_pdiv[c]; m_pend[c] = 0; end
                m_left[c] = m_act[c] + 1;
            end else if (!ch_en[c] && !m_lvl[c]) begin
                m_left[c] = m_act[c] + 1;
            end else begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_lvl[c]  = !m_lvl[c];
                    m_tick[c] = m_lvl[c];
                    if (m_pend[c]) begin m_act[c] = m_pdiv[c]; m_pend[c] = 0; end
                    m_left[c] = m_act[c] + 1;
                end
            end
            if (cfg_we && int'(cfg_sel) == c) begin
                m_pdiv[c] = longint'(cfg_div);
                m_pend[c] = 1;
            end
        end
    endfunction

    function automatic logic [3*NUM_CH-1:0] m_vec();
        logic [NUM_CH-1:0] o, t, p;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            o[c] = m_lvl[c]; t[c] = m_tick[c]; p[c] = m_pend[c];
        end
        return {o, t, p};
    endfunction

    task automatic step();
        @(posedge in_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_clk !== '0)     begin errors++; $display("FAIL reset_out got=%b exp=0", out_clk); end
        checks++; if (rise_tick !== '0)   begin errors++; $display("FAIL reset_tick got=%b exp=0", rise_tick); end
        checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL reset_pend got=%b exp=0", cfg_pending); end
        @(negedge in_clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_default();
        int r[$];
        int hi = 0;
        ch_en = '1;
        for (int n = 0; n < 130; n++) begin
            step();
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL default n=%0d got=%b exp=%b", n, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
            if (rise_tick[0]) r.push_back(n);
            if (r.size() == 1 && out_clk[0]) hi++;
        end
        checks++;
        if (r.size() < 2 || r[1] - r[0] != 50) begin
            errors++; $display("FAIL default_period rises=%0d got=%0d exp=50", r.size(), (r.size() < 2) ? -1 : r[1] - r[0]);
        end
        checks++; if (hi != 25) begin errors++; $display("FAIL default_high got=%0d exp=25", hi); end
    endtask

    task automatic test_write_mid_high();
        int r[$];
        int k = 0;
        while (k < 200 && !(m_lvl[1] && m_left[1] == 12)) begin step(); k++; end
        checks++; if (k >= 200) begin errors++; $display("FAIL wr_mid_wait timeout got=%0d exp<200", k); end
        cfg_we = 1'b1; cfg_sel = 3'(1); cfg_div = 32'd4;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_pending[1] !== 1'b1) begin errors++; $display("FAIL wr_mid_pend got=%b exp=1", cfg_pending[1]); end
        for (int n = 0; n < 80; n++) begin
            step();
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL wr_mid n=%0d got=%b exp=%b", n, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
            if (rise_tick[1]) r.push_back(n);
        end
        checks++;
        if (r.size() < 2 || r[r.size()-1] - r[r.size()-2] != 10) begin
            errors++; $display("FAIL wr_mid_period rises=%0d exp_period=10", r.size());
        end
        checks++; if (cfg_pending[1] !== 1'b0) begin errors++; $display("FAIL wr_mid_clear got=%b exp=0", cfg_pending[1]); end
    endtask

    task automatic test_terminal_write();
        int k = 0;
        int ticks = 0;
        while (k < 200 && m_left[2] != 1) begin step(); k++; end
        checks++; if (k >= 200) begin errors++; $display("FAIL term_wait timeout got=%0d exp<200", k); end
        cfg_we = 1'b1; cfg_sel = 3'(2); cfg_div = 32'd0;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_pending[2] !== 1'b1) begin errors++; $display("FAIL term_pend got=%b exp=1", cfg_pending[2]); end
        for (int n = 0; n < 60; n++) begin
            step();
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL term n=%0d got=%b exp=%b", n, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
        end
        checks++; if (cfg_pending[2] !== 1'b0) begin errors++; $display("FAIL term_clear got=%b exp=0", cfg_pending[2]); end
        for (int n = 0; n < 4; n++) begin step(); ticks += int'(rise_tick[2]); end
        checks++; if (ticks != 2) begin errors++; $display("FAIL term_div0_ticks got=%0d exp=2", ticks); end
    endtask

    task automatic test_disable_high();
        int k = 0;
        int hi = 0;
        int rises = 0;
        while (k < 200 && !(m_lvl[0] && m_left[0] == 23)) begin step(); k++; end
        checks++; if (k >= 200) begin errors++; $display("FAIL dis_wait timeout got=%0d exp<200", k); end
        ch_en[0] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            step();
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL dis n=%0d got=%b exp=%b", n, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
            hi += int'(out_clk[0]);
            rises += int'(rise_tick[0]);
        end
        checks++; if (hi != 22) begin errors++; $display("FAIL dis_hold_high got=%0d exp=22", hi); end
        checks++; if (rises != 0) begin errors++; $display("FAIL dis_no_rise got=%0d exp=0", rises); end
        ch_en[0] = 1'b1;
        k = 0;
        while (k < 100) begin
            step(); k++;
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL reen n=%0d got=%b exp=%b", k, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
            if (rise_tick[0]) break;
        end
        checks++; if (k != 25) begin errors++; $display("FAIL reen_first_rise got=%0d exp=25", k); end
    endtask

    task automatic test_align();
        int divs[3] = '{2, 5, 9};
        int first[3] = '{-1, -1, -1};
        ch_en = '1;
        for (int c = 0; c < 3; c++) begin
            cfg_we = 1'b1; cfg_sel = 3'(c); cfg_div = 32'(divs[c]);
            step();
        end
        cfg_we = 1'b0;
        align = 1'b1;
        step();
        align = 1'b0;
        checks++; if (out_clk !== '0)     begin errors++; $display("FAIL align_out got=%b exp=0", out_clk); end
        checks++; if (rise_tick !== '0)   begin errors++; $display("FAIL align_tick got=%b exp=0", rise_tick); end
        checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL align_pend got=%b exp=0", cfg_pending); end
        for (int n = 1; n <= 40; n++) begin
            step();
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL align n=%0d got=%b exp=%b", n, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
            for (int c = 0; c < 3; c++) if (rise_tick[c] && first[c] < 0) first[c] = n;
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (first[c] != divs[c] + 1) begin
                errors++; $display("FAIL align_rise ch=%0d got=%0d exp=%0d", c, first[c], divs[c] + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                int idx = int'($urandom_range(0, NUM_CH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_sel = 3'($urandom_range(0, 7));
            cfg_div = 32'($urandom_range(0, 12));
            align   = ($urandom_range(0, 63) == 0);
            step();
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL random n=%0d got=%b exp=%b", n, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
        end
        cfg_we = 1'b0;
        align  = 1'b0;
    endtask

    task automatic test_bad_sel();
        align = 1'b1;
        step();
        align = 1'b0;
        for (int s = 5; s <= 7; s++) begin
            cfg_we = 1'b1; cfg_sel = 3'(s); cfg_div = 32'd3;
            step();
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL badsel s=%0d got=%b exp=%b", s, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
        end
        cfg_we = 1'b0;
        checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL badsel_pend got=%b exp=0", cfg_pending); end
    endtask

    task automatic test_async_reset();
        int k = 0;
        ch_en = '1;
        cfg_we = 1'b1; cfg_sel = 3'(0); cfg_div = 32'd2;
        step();
        cfg_sel = 3'(3); cfg_div = 32'd7;
        step();
        cfg_we = 1'b0;
        checks++;
        if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
            errors++; $display("FAIL arst_pre got=%b exp=%b", {out_clk, rise_tick, cfg_pending}, m_vec());
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_clk !== '0)     begin errors++; $display("FAIL arst_out got=%b exp=0", out_clk); end
        checks++; if (rise_tick !== '0)   begin errors++; $display("FAIL arst_tick got=%b exp=0", rise_tick); end
        checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL arst_pend got=%b exp=0", cfg_pending); end
        @(negedge in_clk);
        reset_n = 1'b1;
        while (k < 100) begin
            step(); k++;
            checks++;
            if ({out_clk, rise_tick, cfg_pending} !== m_vec()) begin
                errors++; $display("FAIL arst_run n=%0d got=%b exp=%b", k, {out_clk, rise_tick, cfg_pending}, m_vec());
            end
            if (rise_tick[0]) break;
        end
        checks++; if (k != 25) begin errors++; $display("FAIL arst_div_revert got=%0d exp=25", k); end
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_default();
        test_write_mid_high();
        test_terminal_write();
        test_disable_high();
        test_align();
        test_random();
        test_bad_sel();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
